// File: rtl/i2s_sample_sink_if.sv
// Sample hand-off between the wave generator and the I2S sink:
// 16-bit data with a one-cycle valid pulse, and backpressure in the other direction.
interface i2s_sample_sink_if;
  logic [15:0] i_sample;
  logic        i_pulse;
  logic        o_pause;

  modport master (output i_sample, output i_pulse, input o_pause);
  modport slave  (input  i_sample, input  i_pulse, output o_pause);
endinterface

// File: rtl/i2s_sample_sink.sv
// Sample sink: buffers mono samples in a FIFO and plays one per frame out of a
// free-running I2S transmitter, duplicating the sample into both slots.
module i2s_sample_sink #(
  parameter int DEPTH     = 16,
  parameter int PAUSE_LVL = 12,
  parameter int BCLK_HALF = 8,
  parameter int SLOT_BITS = 32
) (
  input  logic                   i_clk48,
  input  logic                   i_rst48_n,
  i2s_sample_sink_if.slave       smp,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_bclk,
  output logic                   o_lrclk,
  output logic                   o_sdata,
  output logic                   o_overflow,
  output logic                   o_underrun
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int DC_W  = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int FRAME = 2 * SLOT_BITS;
  localparam int BC_W  = $clog2(FRAME);

  localparam logic [DC_W-1:0]  DC_MAX    = DC_W'(BCLK_HALF - 1);
  localparam logic [BC_W-1:0]  BC_MAX    = BC_W'(FRAME - 1);
  localparam logic [BC_W-1:0]  SLOT_N    = BC_W'(SLOT_BITS);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_PAUSE = LVL_W'(PAUSE_LVL);

  logic [15:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [15:0]      hold;
  logic [DC_W-1:0]  dc;
  logic [BC_W-1:0]  bc;

  logic             fifo_full;
  logic             fifo_empty;
  logic             dc_wrap;
  logic             fall_evt;
  logic             frame_start;
  logic             do_push;
  logic             do_pop;
  logic [BC_W-1:0]  bc_nxt;
  logic [BC_W-1:0]  slot;
  logic [15:0]      hold_nxt;
  logic             sdata_nxt;

  assign fifo_full   = (o_level == LVL_FULL);
  assign fifo_empty  = (o_level == '0);
  assign dc_wrap     = (dc == DC_MAX);
  assign fall_evt    = o_bclk && dc_wrap;
  // Full/empty are judged on the occupancy before this cycle's pop/push.
  assign do_push     = smp.i_pulse && !fifo_full;
  assign frame_start = fall_evt && (bc_nxt == '0);
  assign do_pop      = frame_start && !fifo_empty;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    bc_nxt    = (bc == BC_MAX) ? '0 : bc + 1'b1;
    hold_nxt  = hold;
    slot      = (bc_nxt >= SLOT_N) ? bc_nxt - SLOT_N : bc_nxt;
    sdata_nxt = 1'b0;
    if (frame_start) begin
      hold_nxt = do_pop ? mem[rd_ptr] : 16'h0000;
    end
    // One-bit I2S delay: slot bit 1 carries the MSB, bit 16 the LSB.
    if (slot >= BC_W'(1) && slot <= BC_W'(16)) begin
      sdata_nxt = hold_nxt[4'(16 - int'(slot))];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk48 or negedge i_rst48_n) begin
    if (!i_rst48_n) begin
      dc         <= '0;
      bc         <= BC_MAX;
      o_bclk     <= 1'b0;
      o_lrclk    <= 1'b0;
      o_sdata    <= 1'b0;
      hold       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_level    <= '0;
      smp.o_pause <= 1'b0;
      o_overflow <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      dc <= dc_wrap ? '0 : dc + 1'b1;
      if (dc_wrap) begin
        o_bclk <= ~o_bclk;
      end

      // Data and word select move only on falling BCLK, stable for the DAC's rising edge.
      if (fall_evt) begin
        bc      <= bc_nxt;
        o_lrclk <= (bc_nxt >= SLOT_N);
        o_sdata <= sdata_nxt;
        hold    <= hold_nxt;
      end

      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      o_level     <= o_level + LVL_W'(do_push) - LVL_W'(do_pop);
      smp.o_pause <= (o_level >= LVL_PAUSE);
      o_overflow  <= smp.i_pulse && fifo_full;
      o_underrun  <= frame_start && fifo_empty;
    end
  end

  // NOTE: the storage array has no reset; the pointers and level define which
  // entries are valid, so clearing the data would only cost reset fanout.
  always_ff @(posedge i_clk48) begin
    if (do_push) begin
      mem[wr_ptr] <= smp.i_sample;
    end
  end

endmodule

// File: doc/i2s_sample_sink.md
Name: i2s_sample_sink

Overview:
- Consumer end of the oscillator sample interface: accepts 16-bit mono samples on a valid pulse, buffers them in a FIFO, and asserts pause (backpressure) towards the generator when the FIFO fills.
- Drains one sample per frame into a free-running I2S transmitter driving the DAC. The same sample is sent in both the left and right slots.
- Sits between the wave generator output and the board DAC pins, in the 48MHz domain.

Parameters:
- DEPTH, 16: FIFO entries; power of two, ≥4.
- PAUSE_LVL, 12: fill level at or above which o_pause asserts; 1 ≤ PAUSE_LVL ≤ DEPTH.
- BCLK_HALF, 8: i_clk48 cycles per BCLK half-period, ≥2. Default gives 3MHz BCLK.
- SLOT_BITS, 32: BCLK periods per channel slot, ≥17. Default gives a 46.875kHz frame.

Ports:
- i_clk48  in  1  48MHz clock.
- i_rst48_n  in  1  Reset, asynchronous, active-low.
- i_sample  in  16  Sample data, two's complement.
- i_pulse  in  1  Sample valid, one-cycle pulse.
- o_pause  out  1  Backpressure to the generator.
- o_level  out  $clog2(DEPTH)+1  FIFO occupancy.
- o_bclk  out  1  I2S bit clock.
- o_lrclk  out  1  I2S word select; 0 = left.
- o_sdata  out  1  I2S serial data.
- o_overflow  out  1  One-cycle pulse: a sample was dropped because the FIFO was full.
- o_underrun  out  1  One-cycle pulse: frame start found the FIFO empty.

Behaviour:
- Reset is asynchronous and active-low; all state clears immediately, including mid-frame. Reset values:
  - o_pause=0, o_level=0, o_bclk=0, o_lrclk=0, o_sdata=0, o_overflow=0, o_underrun=0.
  - FIFO empty; hold register=0.
  - Divider count dc=0; bit count bc=2*SLOT_BITS-1.
- Write:
  - i_pulse with FIFO not full → push i_sample at the next edge.
  - i_pulse with FIFO full → sample discarded; o_overflow=1 for exactly the next cycle.
- Pause:
  - o_pause is registered: o_pause = (o_level ≥ PAUSE_LVL), one cycle after o_level changes.
  - Samples arriving while o_pause=1 are still accepted if space remains.
- Divider:
  - dc counts 0..BCLK_HALF-1 and wraps.
  - On the cycle dc==BCLK_HALF-1, o_bclk toggles at the next edge.
- Falling-BCLK event (o_bclk==1 && dc==BCLK_HALF-1). At the next edge:
  - bc ← (bc+1) mod 2*SLOT_BITS.
  - o_lrclk ← (bc_next ≥ SLOT_BITS).
  - o_sdata ← bit(bc_next).
- Frame start (falling event with bc_next==0):
  - FIFO non-empty → pop head into the hold register; o_level decrements.
  - FIFO empty → hold register ← 0; o_underrun=1 for the next cycle.
  - The popped value drives that same cycle's bit computation; it is used for both slots.
- Slot bit mapping, with s = bc_next mod SLOT_BITS (one-bit I2S delay, MSB first):
  - s==0 → 0.
  - 1≤s≤16 → hold[16-s].
  - s>16 → 0.
- Data and o_lrclk change only on falling-BCLK events, so the DAC samples them on the BCLK rising edge.
- Simultaneous push and pop in one cycle (including when full or empty):
  - Full: push rejected (overflow), pop proceeds, o_level = DEPTH-1.
  - Empty: underrun declared, the pushed sample is stored, o_level = 1.
  - Otherwise: o_level unchanged.
- Pointers wrap modulo DEPTH; o_level never exceeds DEPTH.
- Latency: first sample pushed after reset appears at o_sdata (MSB) one BCLK after the first falling event, i.e. cycle 2*BCLK_HALF + 2*BCLK_HALF after reset release.

Test Plan:
- Reset, no input, defaults → o_bclk toggles every 8 cycles; o_lrclk period 1024 cycles; first frame start at cycle 16 sets o_underrun=1 for one cycle; o_sdata stays 0.
- Push 0xA5C3 before the first frame start → left slot bits 1..16 = 1010_0101_1100_0011, right slot identical, all other bits 0, o_level returns to 0.
- Push 12 samples back-to-back with no drain → o_level=12, o_pause=1 one cycle later. Drain one → o_level=11, o_pause=0 next cycle.
- Fill to 16, then one more i_pulse → o_overflow pulses once, o_level stays 16, and the dropped value never appears on o_sdata.
- Push coincident with frame-start pop at o_level=16 → overflow pulse, o_level=15. Repeat at o_level=0 → underrun pulse, o_level=1, and that sample is sent next frame.
- Assert i_rst48_n low mid-slot (bc=20) → all outputs 0 asynchronously. After release, the frame restarts at bc=0 on the first falling event; FIFO is empty.
